llr_load_sched: RTL and testbench

Load sequencer and read-port scheduler for the 1023-entry LLR shift memory `llr_mem`. It accepts a codeword's channel LLRs as a valid/ready stream of 64-bit words and drives `llr_mem` write-enable so each word shifts in. It then serves the two `llr_mem` read ports to two requesters: the decoder core, which has priority, and an aux readback/debug port, which is protected against starvation by aging. It sits between the input framer and the decoder core.

---
 rtl/llr_pkg.sv | 46 ++++
 rtl/llr_read_arb.sv | 109 ++++++++++
 rtl/llr_load_sched.sv | 125 ++++++++++++
 tb/tb_llr_load_sched.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llr_pkg.sv
// Shared types and constants for the LLR memory load sequencer and its read arbiter.
package llr_pkg;

   localparam int LLR_W     = 7;
   localparam int POS_W     = 10;
   localparam int MEM_DEPTH = 1023;
   localparam int WORD_W    = 64;
   localparam int CNT_W     = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SERVE = 2'd2
   } state_t;

   localparam logic [1:0] LEN_255      = 2'd0;
   localparam logic [1:0] LEN_511      = 2'd1;
   localparam logic [1:0] LEN_1023     = 2'd2;
   localparam logic [1:0] LEN_1023_ALT = 2'd3;

   // n is the code length; wlast is the word count minus one, which fits the 7-bit counter
   typedef struct packed {
      logic [POS_W-1:0] n;
      logic [CNT_W-1:0] wlast;
   } len_cfg_t;

   function automatic len_cfg_t len_decode(input logic [1:0] len);
      len_cfg_t cfg;
      case (len)
         LEN_255: begin
            cfg.n     = 10'd255;
            cfg.wlast = 7'd31;
         end
         LEN_511: begin
            cfg.n     = 10'd511;
            cfg.wlast = 7'd63;
         end
         default: begin
            cfg.n     = 10'd1023;
            cfg.wlast = 7'd127;
         end
      endcase
      return cfg;
   endfunction

endpackage

// File: rtl/llr_read_arb.sv
// Read-port arbiter for llr_mem: core priority with aging for aux, address mux,
// and one-cycle-latency response tagging with out-of-range masking.
module llr_read_arb
   import llr_pkg::*;
#(
   parameter int MAX_AGE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             serve,
   input  logic [POS_W-1:0] n,
   input  logic             c_req,
   input  logic [POS_W-1:0] c_pos0,
   input  logic [POS_W-1:0] c_pos1,
   input  logic             a_req,
   input  logic [POS_W-1:0] a_pos,
   input  logic [LLR_W-1:0] mem_data0,
   input  logic [LLR_W-1:0] mem_data1,
   output logic             c_gnt,
   output logic             a_gnt,
   output logic [POS_W-1:0] mem_pos0,
   output logic [POS_W-1:0] mem_pos1,
   output logic             c_rvalid,
   output logic             c_oob,
   output logic [LLR_W-1:0] c_data0,
   output logic [LLR_W-1:0] c_data1,
   output logic             a_rvalid,
   output logic             a_oob,
   output logic [LLR_W-1:0] a_data
);

   localparam int AGE_W = (MAX_AGE < 1) ? 1 : $clog2(MAX_AGE + 1);
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_AGE);

   logic [AGE_W-1:0] age_q;
   logic             age_sat;
   logic             c_oob0;
   logic             c_oob1;
   logic             a_oob0;

   logic             c_rvalid_q;
   logic             c_oob_q;
   logic             c_m0_q;
   logic             c_m1_q;
   logic             a_rvalid_q;
   logic             a_oob_q;
   logic             a_m_q;

   assign age_sat = (age_q == AGE_MAX);

   assign a_gnt = serve & a_req & (~c_req | age_sat);
   assign c_gnt = serve & c_req & ~a_gnt;

   assign c_oob0 = (c_pos0 >= n);
   assign c_oob1 = (c_pos1 >= n);
   assign a_oob0 = (a_pos >= n);

   always_comb begin
      mem_pos0 = '0;
      mem_pos1 = '0;
      if (c_gnt) begin
         mem_pos0 = c_pos0;
         mem_pos1 = c_pos1;
      end else if (a_gnt) begin
         mem_pos0 = a_pos;
      end
   end

   // age counts core wins while aux keeps waiting; any aux win or aux idle resets it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age_q <= '0;
      end else if (!a_req || a_gnt) begin
         age_q <= '0;
      end else if (c_gnt && !age_sat) begin
         age_q <= age_q + AGE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_rvalid_q <= 1'b0;
         c_oob_q    <= 1'b0;
         c_m0_q     <= 1'b0;
         c_m1_q     <= 1'b0;
         a_rvalid_q <= 1'b0;
         a_oob_q    <= 1'b0;
         a_m_q      <= 1'b0;
      end else begin
         c_rvalid_q <= c_gnt;
         c_oob_q    <= c_gnt & (c_oob0 | c_oob1);
         c_m0_q     <= c_gnt & ~c_oob0;
         c_m1_q     <= c_gnt & ~c_oob1;
         a_rvalid_q <= a_gnt;
         a_oob_q    <= a_gnt & a_oob0;
         a_m_q      <= a_gnt & ~a_oob0;
      end
   end

   // masks also cover the no-response case, so idle data reads as zero
   assign c_rvalid = c_rvalid_q;
   assign c_oob    = c_oob_q;
   assign c_data0  = c_m0_q ? mem_data0 : '0;
   assign c_data1  = c_m1_q ? mem_data1 : '0;
   assign a_rvalid = a_rvalid_q;
   assign a_oob    = a_oob_q;
   assign a_data   = a_m_q ? mem_data0 : '0;

endmodule

// File: rtl/llr_load_sched.sv
// Load sequencer for the LLR shift memory plus read-port scheduling between
// the decoder core and the aux readback port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no codeword in flight; waits for i_start, latches length
// ST_LOAD  | accepting W stream words, each shifted into llr_mem
// ST_SERVE | codeword resident; read ports arbitrated until i_release
module llr_load_sched
   import llr_pkg::*;
#(
   parameter int MAX_AGE = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [1:0]        i_len,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [WORD_W-1:0] i_in_data,
   input  logic              i_release,
   output logic              o_busy,
   output logic              o_load_done,
   input  logic              i_c_req,
   input  logic [POS_W-1:0]  i_c_pos0,
   input  logic [POS_W-1:0]  i_c_pos1,
   output logic              o_c_gnt,
   output logic              o_c_rvalid,
   output logic [LLR_W-1:0]  o_c_data0,
   output logic [LLR_W-1:0]  o_c_data1,
   output logic              o_c_oob,
   input  logic              i_a_req,
   input  logic [POS_W-1:0]  i_a_pos,
   output logic              o_a_gnt,
   output logic              o_a_rvalid,
   output logic [LLR_W-1:0]  o_a_data,
   output logic              o_a_oob,
   output logic              o_mem_wen,
   output logic [WORD_W-1:0] o_mem_data,
   output logic [POS_W-1:0]  o_mem_pos0,
   output logic [POS_W-1:0]  o_mem_pos1,
   input  logic [LLR_W-1:0]  i_mem_data0,
   input  logic [LLR_W-1:0]  i_mem_data1
);

   state_t           state_q;
   state_t           state_d;
   len_cfg_t         cfg_q;
   logic [CNT_W-1:0] cnt_q;
   logic             done_q;
   logic             xfer;
   logic             last_xfer;

   assign o_in_ready = (state_q == ST_LOAD);
   assign xfer       = i_in_valid & o_in_ready;
   assign last_xfer  = xfer & (cnt_q == cfg_q.wlast);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (i_start)   state_d = ST_LOAD;
         ST_LOAD:  if (last_xfer) state_d = ST_SERVE;
         ST_SERVE: if (i_release) state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   // done is registered off the final transfer so it lands in the first SERVE cycle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cfg_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= last_xfer;
         if ((state_q == ST_IDLE) && i_start) begin
            cfg_q <= len_decode(i_len);
            cnt_q <= '0;
         end else if (xfer) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign o_busy      = (state_q != ST_IDLE);
   assign o_load_done = done_q;
   assign o_mem_wen   = xfer;
   assign o_mem_data  = i_in_data;

   llr_read_arb #(
      .MAX_AGE (MAX_AGE)
   ) u_arb (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .serve     (state_q == ST_SERVE),
      .n         (cfg_q.n),
      .c_req     (i_c_req),
      .c_pos0    (i_c_pos0),
      .c_pos1    (i_c_pos1),
      .a_req     (i_a_req),
      .a_pos     (i_a_pos),
      .mem_data0 (i_mem_data0),
      .mem_data1 (i_mem_data1),
      .c_gnt     (o_c_gnt),
      .a_gnt     (o_a_gnt),
      .mem_pos0  (o_mem_pos0),
      .mem_pos1  (o_mem_pos1),
      .c_rvalid  (o_c_rvalid),
      .c_oob     (o_c_oob),
      .c_data0   (o_c_data0),
      .c_data1   (o_c_data1),
      .a_rvalid  (o_a_rvalid),
      .a_oob     (o_a_oob),
      .a_data    (o_a_data)
   );

endmodule

// File: tb/tb_llr_load_sched.sv
// Randomized bench for llr_load_sched with a behavioural llr_mem and a
// reference model built from the stream order and arbitration rules.
module tb_llr_load_sched;

   localparam int MAX_AGE = 8;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_start;
   logic [1:0]  i_len;
   logic        i_in_valid;
   logic        o_in_ready;
   logic [63:0] i_in_data;
   logic        i_release;
   logic        o_busy;
   logic        o_load_done;
   logic        i_c_req;
   logic [9:0]  i_c_pos0;
   logic [9:0]  i_c_pos1;
   logic        o_c_gnt;
   logic        o_c_rvalid;
   logic [6:0]  o_c_data0;
   logic [6:0]  o_c_data1;
   logic        o_c_oob;
   logic        i_a_req;
   logic [9:0]  i_a_pos;
   logic        o_a_gnt;
   logic        o_a_rvalid;
   logic [6:0]  o_a_data;
   logic        o_a_oob;
   logic        o_mem_wen;
   logic [63:0] o_mem_data;
   logic [9:0]  o_mem_pos0;
   logic [9:0]  o_mem_pos1;
   logic [6:0]  i_mem_data0;
   logic [6:0]  i_mem_data1;

   llr_load_sched #(.MAX_AGE(MAX_AGE)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start),
      .i_len       (i_len),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_in_data   (i_in_data),
      .i_release   (i_release),
      .o_busy      (o_busy),
      .o_load_done (o_load_done),
      .i_c_req     (i_c_req),
      .i_c_pos0    (i_c_pos0),
      .i_c_pos1    (i_c_pos1),
      .o_c_gnt     (o_c_gnt),
      .o_c_rvalid  (o_c_rvalid),
      .o_c_data0   (o_c_data0),
      .o_c_data1   (o_c_data1),
      .o_c_oob     (o_c_oob),
      .i_a_req     (i_a_req),
      .i_a_pos     (i_a_pos),
      .o_a_gnt     (o_a_gnt),
      .o_a_rvalid  (o_a_rvalid),
      .o_a_data    (o_a_data),
      .o_a_oob     (o_a_oob),
      .o_mem_wen   (o_mem_wen),
      .o_mem_data  (o_mem_data),
      .o_mem_pos0  (o_mem_pos0),
      .o_mem_pos1  (o_mem_pos1),
      .i_mem_data0 (i_mem_data0),
      .i_mem_data1 (i_mem_data1)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // llr_mem stand-in: each write shifts every entry up by 8 positions
   logic [6:0] mem [0:1022];
   always @(posedge i_clk) begin
      if (o_mem_wen) begin
         for (int p = 1022; p >= 8; p--) mem[p] <= mem[p-8];
         for (int l = 0; l < 8; l++) mem[l] <= o_mem_data[8*l +: 7];
      end
      i_mem_data0 <= (o_mem_pos0 < 10'd1023) ? mem[o_mem_pos0] : 7'd0;
      i_mem_data1 <= (o_mem_pos1 < 10'd1023) ? mem[o_mem_pos1] : 7'd0;
   end

   int          n_cmp = 0;
   int          n_err = 0;
   int          model_n;
   int          model_w;
   logic [63:0] words[$];
   bit          model_serve;
   bit          model_busy;
   bit          exp_done;
   int          wait_cnt;
   bit          p_c_rv, p_c_oob, p_a_rv, p_a_oob;
   logic [6:0]  p_c_d0, p_c_d1, p_a_d;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // index k arrives in word W-1-k/8 of the stream, lane k%8
   function automatic logic [6:0] ref_llr(input int k);
      int j;
      if (k >= model_n) return 7'd0;
      j = model_w - 1 - k / 8;
      return words[j][8*(k%8) +: 7];
   endfunction

   function automatic int rand_pos();
      case ($urandom_range(0, 5))
         0: return model_n - 1;
         1: return model_n;
         2: return 1023;
         3: return 0;
         default: return $urandom_range(0, 1023);
      endcase
   endfunction

   task automatic clear_pending();
      p_c_rv = 0; p_c_oob = 0; p_a_rv = 0; p_a_oob = 0;
      p_c_d0 = 0; p_c_d1 = 0; p_a_d = 0;
   endtask

   task automatic next_cycle();
      @(posedge i_clk);
      #1;
   endtask

   task automatic serve_cycle(input bit cr, input int c0, input int c1,
                              input bit ar, input int ap, input bit rel);
      bit eg_a, eg_c;
      int ep0, ep1;
      i_c_req = cr; i_c_pos0 = c0[9:0]; i_c_pos1 = c1[9:0];
      i_a_req = ar; i_a_pos = ap[9:0]; i_release = rel;
      i_in_valid = $urandom_range(0, 1);
      #1;
      eg_a = model_serve && ar && (!cr || wait_cnt == MAX_AGE);
      eg_c = model_serve && cr && !eg_a;
      ep0 = eg_c ? c0 : (eg_a ? ap : 0);
      ep1 = eg_c ? c1 : 0;
      chk("c_gnt", o_c_gnt, eg_c);
      chk("a_gnt", o_a_gnt, eg_a);
      chk("mem_pos0", o_mem_pos0, ep0);
      chk("mem_pos1", o_mem_pos1, ep1);
      chk("busy", o_busy, model_busy);
      chk("in_ready", o_in_ready, 0);
      chk("mem_wen", o_mem_wen, 0);
      chk("load_done", o_load_done, exp_done);
      chk("c_rvalid", o_c_rvalid, p_c_rv);
      chk("c_oob", o_c_oob, p_c_oob);
      chk("c_data0", o_c_data0, p_c_d0);
      chk("c_data1", o_c_data1, p_c_d1);
      chk("a_rvalid", o_a_rvalid, p_a_rv);
      chk("a_oob", o_a_oob, p_a_oob);
      chk("a_data", o_a_data, p_a_d);
      p_c_rv  = eg_c;
      p_c_oob = eg_c && (c0 >= model_n || c1 >= model_n);
      p_c_d0  = eg_c ? ref_llr(c0) : 7'd0;
      p_c_d1  = eg_c ? ref_llr(c1) : 7'd0;
      p_a_rv  = eg_a;
      p_a_oob = eg_a && (ap >= model_n);
      p_a_d   = eg_a ? ref_llr(ap) : 7'd0;
      if (!ar || eg_a) wait_cnt = 0;
      else if (eg_c && wait_cnt < MAX_AGE) wait_cnt++;
      exp_done = 0;
      if (model_serve && rel) begin
         model_serve = 0;
         model_busy  = 0;
      end
      next_cycle();
   endtask

   // mode 0: back-to-back, 1: valid every other cycle, 2: random valid
   task automatic do_load(input int len, input int mode, input int abort_after);
      int cnt, cyc, wens;
      bit v;
      logic [63:0] d;
      i_c_req = 0; i_a_req = 0; i_release = 0; i_in_valid = 1;
      i_len = len[1:0]; i_start = 1;
      #1;
      chk("start_ready", o_in_ready, 0);
      chk("start_wen", o_mem_wen, 0);
      chk("start_busy", o_busy, 0);
      chk("start_c_rvalid", o_c_rvalid, p_c_rv);
      clear_pending();
      next_cycle();
      i_start = 0;
      model_n = (len == 0) ? 255 : (len == 1) ? 511 : 1023;
      model_w = (len == 0) ? 32 : (len == 1) ? 64 : 128;
      model_busy = 1;
      wait_cnt = 0;
      words.delete();
      cnt = 0; cyc = 0; wens = 0;
      while (cnt < model_w && cyc < 4000) begin
         if (abort_after >= 0 && cnt == abort_after) break;
         v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         d = {$urandom, $urandom};
         i_in_valid = v; i_in_data = d;
         i_c_req = 1'($urandom_range(0, 1));
         #1;
         chk("ld_ready", o_in_ready, 1);
         chk("ld_wen", o_mem_wen, v);
         chk("ld_data", o_mem_data, d);
         chk("ld_done", o_load_done, 0);
         chk("ld_busy", o_busy, 1);
         chk("ld_c_gnt", o_c_gnt, 0);
         if (o_mem_wen) wens++;
         if (v) begin
            words.push_back(d);
            cnt++;
         end
         next_cycle();
         cyc++;
      end
      i_in_valid = 0; i_c_req = 0;
      if (abort_after < 0) begin
         chk("ld_wen_count", wens, model_w);
         model_serve = 1;
         exp_done = 1;
      end
   endtask

   task automatic rand_serve(input int cycles);
      for (int i = 0; i < cycles; i++)
         serve_cycle(1'($urandom_range(0, 1)), rand_pos(), rand_pos(),
                     1'($urandom_range(0, 1)), rand_pos(), 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_ready"}, o_in_ready, 0);
      chk({tag, "_wen"}, o_mem_wen, 0);
      chk({tag, "_done"}, o_load_done, 0);
      chk({tag, "_gnts"}, {o_c_gnt, o_a_gnt}, 0);
      chk({tag, "_rvalid"}, {o_c_rvalid, o_a_rvalid}, 0);
      chk({tag, "_oob"}, {o_c_oob, o_a_oob}, 0);
      chk({tag, "_data"}, {o_c_data0, o_c_data1, o_a_data}, 0);
      chk({tag, "_pos"}, {o_mem_pos0, o_mem_pos1}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n = 0; i_start = 0; i_len = 0; i_in_valid = 1; i_in_data = '0;
      i_release = 0; i_c_req = 1; i_c_pos0 = 0; i_c_pos1 = 0;
      i_a_req = 1; i_a_pos = 0;
      model_n = 255; model_w = 32; model_serve = 0; model_busy = 0;
      exp_done = 0; wait_cnt = 0;
      clear_pending();
      #1;
      check_all_zero("rst");
      next_cycle();
      next_cycle();
      i_rst_n = 1;
      i_c_req = 0; i_a_req = 0; i_in_valid = 0;
      next_cycle();

      do_load(0, 0, -1);
      serve_cycle(1, 3, 300, 0, 0, 0);
      serve_cycle(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 27; i++) serve_cycle(1, $urandom_range(0, 254), i, 1, i, 0);
      i_start = 1;
      rand_serve(150);
      i_start = 0;
      serve_cycle(1, 5, 6, 0, 0, 1);
      serve_cycle(1, 7, 8, 1, 9, 0);
      serve_cycle(0, 0, 0, 1, 9, 0);

      do_load($urandom_range(2, 3), 1, -1);
      rand_serve(200);
      serve_cycle(0, 0, 0, 0, 0, 1);
      serve_cycle(0, 0, 0, 0, 0, 0);

      do_load(1, 2, 10);
      i_in_valid = 1; i_c_req = 1; i_a_req = 1;
      i_rst_n = 0;
      #1;
      check_all_zero("midrst");
      model_serve = 0; model_busy = 0; wait_cnt = 0;
      clear_pending();
      next_cycle();
      i_rst_n = 1;
      i_c_req = 0; i_a_req = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("post_rst_ready", o_in_ready, 0);
         chk("post_rst_wen", o_mem_wen, 0);
         next_cycle();
      end
      do_load(1, 2, -1);
      rand_serve(200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
